// File: rtl/ladder_seq_fault_pkg.sv
// Shared constants for the fault-tolerant ladder sequencer, the key scanner and the point unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ladder_seq_fault_pkg;

  // Scanner checkpoint commands carried on op_code
  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_SNAP    = 2'b01;  // current key/key_cnt -> tmp
  localparam logic [1:0] OP_COMMIT  = 2'b10;  // tmp -> backup
  localparam logic [1:0] OP_RESTORE = 2'b11;  // backup -> current

  // Scanner pre-judge results on key_state
  localparam logic [1:0] KEY_NORMAL  = 2'b00;
  localparam logic [1:0] KEY_IS_ZERO = 2'b01;
  localparam logic [1:0] KEY_IS_ONE  = 2'b11;

  // Point-unit command selects on pt_sel
  localparam logic [1:0] PT_IDLE  = 2'b00;
  localparam logic [1:0] PT_STEP  = 2'b01;
  localparam logic [1:0] PT_REST  = 2'b10;
  localparam logic [1:0] PT_FINAL = 2'b11;

  // Sequencer state encoding
  typedef logic [4:0] state_t;
  localparam state_t S_IDLE    = 5'd0;
  localparam state_t S_LOAD    = 5'd1;
  localparam state_t S_CHECK   = 5'd2;
  localparam state_t S_JUDGE_W = 5'd3;
  localparam state_t S_FIND    = 5'd4;
  localparam state_t S_FIND_W  = 5'd5;
  localparam state_t S_CKPT1   = 5'd6;
  localparam state_t S_CKPT2   = 5'd7;
  localparam state_t S_SCAN    = 5'd8;
  localparam state_t S_SCAN_W  = 5'd9;
  localparam state_t S_STEP    = 5'd10;
  localparam state_t S_STEP_W  = 5'd11;
  localparam state_t S_RESTORE = 5'd12;
  localparam state_t S_REST_W  = 5'd13;
  localparam state_t S_FINAL   = 5'd14;
  localparam state_t S_FINAL_W = 5'd15;
  localparam state_t S_FINISH  = 5'd16;

endpackage

// File: rtl/ladder_seq_fault_if.sv
// Bundles the sequencer's key-scanner and point-unit handshakes into one port.
// Latency: n/a (wiring only).
// Backpressure: none; scanner requests rely on fixed waits, point commands wait on pt_done.
// Ports (master = sequencer side):
//   key_load/key_check/keyfind_en/keyscan_en/op_code -> scanner; ki/key_first_found/key_cnt/key_state <- scanner
//   pt_start/pt_sel/pt_bit -> point unit; pt_done/pt_fault <- point unit
interface ladder_seq_fault_if;

  logic       key_load;
  logic       key_check;
  logic       keyfind_en;
  logic       keyscan_en;
  logic [1:0] op_code;
  logic       ki;
  logic       key_first_found;
  logic [7:0] key_cnt;
  logic [1:0] key_state;

  logic       pt_start;
  logic [1:0] pt_sel;
  logic       pt_bit;
  logic       pt_done;
  logic       pt_fault;

  modport master (
    output key_load, key_check, keyfind_en, keyscan_en, op_code,
    input  ki, key_first_found, key_cnt, key_state,
    output pt_start, pt_sel, pt_bit,
    input  pt_done, pt_fault
  );

  modport slave (
    input  key_load, key_check, keyfind_en, keyscan_en, op_code,
    output ki, key_first_found, key_cnt, key_state,
    input  pt_start, pt_sel, pt_bit,
    output pt_done, pt_fault
  );

endinterface

// File: rtl/ladder_seq_fault.sv
// Sequences one ladder step per key bit with checkpoint/rollback retry on point-unit faults.
// Latency: 5 cycles start->done for key 0/1; otherwise paced by scanner waits and pt_done.
// Backpressure: start ignored while busy; each point command waits for pt_done before moving on.
// Ports: CLK, RST_N (sync, active-low); start; bus (master side of scanner + point handshakes);
//        busy, done, res_inf, res_is_p, error, fault_cnt status outputs.
module ladder_seq_fault
  import ladder_seq_fault_pkg::*;
#(
  parameter int N         = 233,
  parameter int MAX_RETRY = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  ladder_seq_fault_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                res_inf,
  output logic                res_is_p,
  output logic                error,
  output logic [3:0]          fault_cnt
);

  localparam int            RW        = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    N_CNT     = 8'(N);

  state_t        state_q, state_d;
  logic          wait_q, wait_d;          // second cycle of a two-cycle scanner wait
  logic [RW-1:0] retry_q, retry_d;
  logic          pt_bit_q, pt_bit_d;
  logic          res_inf_q, res_inf_d;
  logic          res_is_p_q, res_is_p_d;
  logic          error_q, error_d;
  logic [3:0]    fault_cnt_q, fault_cnt_d;

  logic [RW-1:0] retry_inc;
  logic [3:0]    fault_inc;

  assign retry_inc = retry_q + RW'(1);
  assign fault_inc = (fault_cnt_q == 4'hF) ? 4'hF : fault_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    retry_d     = retry_q;
    pt_bit_d    = pt_bit_q;
    res_inf_d   = res_inf_q;
    res_is_p_d  = res_is_p_q;
    error_d     = error_q;
    fault_cnt_d = fault_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          res_inf_d   = 1'b0;
          res_is_p_d  = 1'b0;
          error_d     = 1'b0;
          fault_cnt_d = 4'd0;
          retry_d     = '0;
        end
      end
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        state_d = S_JUDGE_W;
        wait_d  = 1'b0;
      end
      S_JUDGE_W: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          wait_d = 1'b0;
          if (bus.key_state == KEY_IS_ZERO) begin
            res_inf_d = 1'b1;
            state_d   = S_FINISH;
          end else if (bus.key_state == KEY_IS_ONE) begin
            res_is_p_d = 1'b1;
            state_d    = S_FINISH;
          end else begin
            state_d = S_FIND;
          end
        end
      end
      S_FIND:   state_d = S_FIND_W;
      // key != 0 was established by the pre-judge, so the leading one always turns up
      S_FIND_W: if (bus.key_first_found) state_d = S_CKPT1;
      S_CKPT1:  state_d = S_CKPT2;
      S_CKPT2: begin
        // a commit marks a fresh step, so the consecutive-fault count restarts
        retry_d = '0;
        state_d = (bus.key_cnt == N_CNT) ? S_FINAL : S_SCAN;
      end
      S_SCAN: begin
        state_d = S_SCAN_W;
        wait_d  = 1'b0;
      end
      S_SCAN_W: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          wait_d   = 1'b0;
          pt_bit_d = bus.ki;
          state_d  = S_STEP;
        end
      end
      S_STEP: state_d = S_STEP_W;
      S_STEP_W: begin
        if (bus.pt_done) begin
          if (!bus.pt_fault) begin
            state_d = S_CKPT1;
          end else begin
            fault_cnt_d = fault_inc;
            retry_d     = retry_inc;
            if (retry_inc == RETRY_MAX) begin
              error_d = 1'b1;
              state_d = S_FINISH;
            end else begin
              state_d = S_RESTORE;
            end
          end
        end
      end
      S_RESTORE: state_d = S_REST_W;
      // the restore command's own fault flag is deliberately not inspected
      S_REST_W:  if (bus.pt_done) state_d = S_SCAN;
      S_FINAL:   state_d = S_FINAL_W;
      S_FINAL_W: begin
        if (bus.pt_done) begin
          if (bus.pt_fault) begin
            error_d     = 1'b1;
            fault_cnt_d = fault_inc;
          end
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      wait_q      <= 1'b0;
      retry_q     <= '0;
      pt_bit_q    <= 1'b0;
      res_inf_q   <= 1'b0;
      res_is_p_q  <= 1'b0;
      error_q     <= 1'b0;
      fault_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      retry_q     <= retry_d;
      pt_bit_q    <= pt_bit_d;
      res_inf_q   <= res_inf_d;
      res_is_p_q  <= res_is_p_d;
      error_q     <= error_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  // All strobes are Moore-decoded so each is exactly one state (one cycle) wide
  assign bus.key_load   = (state_q == S_LOAD);
  assign bus.key_check  = (state_q == S_CHECK);
  assign bus.keyfind_en = (state_q == S_FIND);
  assign bus.keyscan_en = (state_q == S_SCAN);
  assign bus.pt_start   = (state_q == S_STEP) || (state_q == S_RESTORE) || (state_q == S_FINAL);
  assign bus.pt_bit     = pt_bit_q;

  logic [1:0] op_code_c;
  logic [1:0] pt_sel_c;

  always_comb begin
    op_code_c = OP_NONE;
    pt_sel_c  = PT_IDLE;
    case (state_q)
      S_CKPT1:             op_code_c = OP_SNAP;
      S_CKPT2:             op_code_c = OP_COMMIT;
      S_RESTORE:           op_code_c = OP_RESTORE;
      default:             op_code_c = OP_NONE;
    endcase
    // select holds across the wait state until pt_done
    case (state_q)
      S_STEP, S_STEP_W:    pt_sel_c = PT_STEP;
      S_RESTORE, S_REST_W: pt_sel_c = PT_REST;
      S_FINAL, S_FINAL_W:  pt_sel_c = PT_FINAL;
      default:             pt_sel_c = PT_IDLE;
    endcase
  end

  assign bus.op_code = op_code_c;
  assign bus.pt_sel  = pt_sel_c;

  assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done      = (state_q == S_FINISH);
  assign res_inf   = res_inf_q;
  assign res_is_p  = res_is_p_q;
  assign error     = error_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_ladder_seq_fault.sv
// Bench for ladder_seq_fault with a behavioural scanner, a point unit and a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ladder_seq_fault;
  import ladder_seq_fault_pkg::*;

  localparam int NB   = 8;
  localparam int MAXR = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, res_inf, res_is_p, error;
  logic [3:0] fault_cnt;

  ladder_seq_fault_if bus();

  ladder_seq_fault #(.N(NB), .MAX_RETRY(MAXR)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .bus(bus),
    .busy(busy), .done(done), .res_inf(res_inf), .res_is_p(res_is_p),
    .error(error), .fault_cnt(fault_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- stimulus plan and expected transactions ----------------
  typedef struct packed { logic [1:0] sel; logic b; } cmd_t;

  logic [7:0] scan_key = 8'h00;
  int         plan_faults [1:8];
  bit         plan_final;
  cmd_t       exp_q [$];
  bit         fault_q [$];
  bit         exp_inf, exp_isp, exp_err;
  int         exp_fc, exp_snap, exp_rest;

  // Key bits after the leading one are stepped MSB first; each faulty attempt is
  // followed by a restore unless it is the MAX_RETRY-th in a row, which aborts.
  task automatic build_expect(input logic [7:0] key);
    int   m, fc;
    cmd_t c;
    exp_q.delete(); fault_q.delete();
    exp_inf = 0; exp_isp = 0; exp_err = 0; fc = 0; exp_snap = 0; exp_rest = 0;
    if (key == 8'd0) exp_inf = 1;
    else if (key == 8'd1) exp_isp = 1;
    else begin
      m = 7;
      while (!key[m]) m--;
      exp_snap = 1;
      for (int s = 1; s <= m && !exp_err; s++) begin
        for (int a = 0; a < plan_faults[s] && a < MAXR; a++) begin
          c.sel = PT_STEP; c.b = key[m-s]; exp_q.push_back(c); fault_q.push_back(1'b1); fc++;
          if (a + 1 == MAXR) exp_err = 1;
          else begin
            c.sel = PT_REST; c.b = 1'b0; exp_q.push_back(c);
            fault_q.push_back(1'($urandom_range(0, 1))); exp_rest++;
          end
        end
        if (!exp_err) begin
          c.sel = PT_STEP; c.b = key[m-s]; exp_q.push_back(c); fault_q.push_back(1'b0); exp_snap++;
        end
      end
      if (!exp_err) begin
        c.sel = PT_FINAL; c.b = 1'b0; exp_q.push_back(c); fault_q.push_back(plan_final);
        if (plan_final) begin exp_err = 1; fc++; end
      end
    end
    exp_fc = (fc > 15) ? 15 : fc;
  endtask

  // ---------------- observations ----------------
  int          n_load, n_check, n_find, n_snap, n_commit, n_oprest, n_step, n_prest, n_final;
  logic [15:0] obs_bits;
  bit          done_seen;
  int          done_cyc, start_cyc;

  task automatic clear_obs();
    n_load = 0; n_check = 0; n_find = 0; n_snap = 0; n_commit = 0; n_oprest = 0;
    n_step = 0; n_prest = 0; n_final = 0; obs_bits = 0; done_seen = 0; done_cyc = 0;
  endtask

  task automatic clear_plan();
    for (int s = 1; s <= 8; s++) plan_faults[s] = 0;
    plan_final = 0;
  endtask

  // ---------------- scanner model: responds one cycle after each request ----------------
  initial begin : scanner
    logic       r_load, r_check, r_find, r_scan, rst;
    logic [1:0] r_op;
    logic [7:0] key;
    int         tmp, bak, fdly, m, kcnt;
    bus.ki = 0; bus.key_first_found = 0; bus.key_cnt = 0; bus.key_state = 0;
    key = 0; tmp = 0; bak = 0; fdly = 0; kcnt = 0;
    forever begin
      @(negedge CLK);
      rst = !RST_N; r_load = bus.key_load; r_check = bus.key_check;
      r_find = bus.keyfind_en; r_scan = bus.keyscan_en; r_op = bus.op_code;
      @(posedge CLK); #1;
      bus.key_first_found = 0;
      if (rst) begin
        fdly = 0; kcnt = 0; bus.key_state = 0;
      end else begin
        if (fdly > 0) begin
          fdly--;
          if (fdly == 0) begin
            m = 7;
            while (m > 0 && !key[m]) m--;
            kcnt = NB - m;
            bus.key_first_found = 1;
          end
        end
        if (r_load) begin key = scan_key; kcnt = 0; bus.key_state = 2'b00; end
        if (r_check) bus.key_state = (key == 8'd0) ? 2'b01 : ((key == 8'd1) ? 2'b11 : 2'b00);
        if (r_find) fdly = $urandom_range(1, 3);
        if (r_scan && kcnt < NB) begin bus.ki = key[NB-1-kcnt]; kcnt++; end
        case (r_op)
          2'b01:   tmp = kcnt;
          2'b10:   bak = tmp;
          2'b11:   kcnt = bak;
          default: ;
        endcase
      end
      bus.key_cnt = 8'(kcnt);
    end
  end

  // ---------------- point unit model: random latency, fault per planned command ----------------
  initial begin : point_unit
    bit pend, pf;
    int dly;
    pend = 0; pf = 0; dly = 0;
    bus.pt_done = 0; bus.pt_fault = 0;
    forever begin
      @(negedge CLK);
      if (!RST_N) pend = 0;
      else if (bus.pt_start) begin
        pend = 1;
        pf   = (fault_q.size() > 0) ? fault_q.pop_front() : 1'b0;
        dly  = $urandom_range(1, 4);
      end
      @(posedge CLK); #1;
      bus.pt_done  = 0;
      bus.pt_fault = 1'($urandom_range(0, 1));   // meaningless outside pt_done
      if (pend) begin
        if (RST_N) begin
          if (dly == 1) begin bus.pt_done = 1; bus.pt_fault = pf; pend = 0; end
          else dly--;
        end
      end else if (!busy && $urandom_range(0, 7) == 0) begin
        bus.pt_done = 1;                          // stray completion while idle
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    logic [4:0] prev_str, cur;
    logic [1:0] prev_op, last_sel;
    logic       last_bit;
    bit         outst;
    cmd_t       c;
    prev_str = 0; prev_op = 0; last_sel = 0; last_bit = 0; outst = 0;
    forever begin
      @(negedge CLK);
      cur = {bus.key_load, bus.key_check, bus.keyfind_en, bus.keyscan_en, bus.pt_start};
      if (!RST_N) begin
        exp_q.delete(); outst = 0; cur = 0;
      end else begin
        if (prev_str != 0) chk("strobe_one_cycle", prev_str & cur, 0);
        if (prev_op != OP_NONE) chk("op_code_one_cycle", bus.op_code == prev_op, 0);
        if (!busy) begin
          chk("idle_pt_sel", bus.pt_sel, PT_IDLE);
          chk("idle_op_code", bus.op_code, OP_NONE);
        end
        if (bus.key_load) n_load++;
        if (bus.key_check) n_check++;
        if (bus.keyfind_en) n_find++;
        if (bus.op_code == OP_SNAP) n_snap++;
        if (bus.op_code == OP_COMMIT) n_commit++;
        if (bus.op_code == OP_RESTORE) n_oprest++;
        if (bus.pt_done && outst) begin
          chk("pt_sel_hold", bus.pt_sel, last_sel);
          if (last_sel == PT_STEP) chk("pt_bit_hold", bus.pt_bit, last_bit);
          outst = 0;
        end
        if (bus.pt_start) begin
          chk("pt_cmd_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            chk("pt_sel", bus.pt_sel, c.sel);
            if (c.sel == PT_STEP) chk("pt_bit", bus.pt_bit, c.b);
          end
          if (bus.pt_sel == PT_STEP) begin n_step++; obs_bits = {obs_bits[14:0], bus.pt_bit}; end
          if (bus.pt_sel == PT_REST) n_prest++;
          if (bus.pt_sel == PT_FINAL) n_final++;
          if (bus.pt_sel == PT_REST) chk("restore_with_op11", bus.op_code, OP_RESTORE);
          last_sel = bus.pt_sel; last_bit = bus.pt_bit; outst = 1;
        end
        if (done) begin
          chk("busy_low_at_done", busy, 0);
          chk("res_inf", res_inf, exp_inf);
          chk("res_is_p", res_is_p, exp_isp);
          chk("error", error, exp_err);
          chk("fault_cnt", fault_cnt, exp_fc);
          chk("all_cmds_issued", exp_q.size(), 0);
          chk("snap_count", n_snap, exp_snap);
          chk("commit_count", n_commit, exp_snap);
          chk("op_restore_count", n_oprest, exp_rest);
          chk("pt_restore_count", n_prest, exp_rest);
          done_seen = 1; done_cyc = cyc;
        end
      end
      prev_str = cur;
      prev_op  = RST_N ? bus.op_code : OP_NONE;
    end
  end

  // ---------------- one multiplication, with stray start pulses while busy ----------------
  task automatic run_test(input logic [7:0] key, input string nm);
    int n;
    scan_key = key; build_expect(key); clear_obs();
    @(negedge CLK); #1; start = 1; start_cyc = cyc;
    @(negedge CLK); #1; start = 0;
    n = 0;
    while (!done_seen && n < 3000) begin
      if (busy && $urandom_range(0, 9) == 0) start = 1;
      @(negedge CLK); #1; start = 0; n++;
    end
    if (!done_seen) $display("FAIL %s_timeout: got no done, expected done within 3000 cycles", nm);
    if (!done_seen) mismatched++;
    compared++;
    // result flags and error must hold once back in IDLE
    @(negedge CLK);
    chk("flags_hold_inf", res_inf, exp_inf);
    chk("flags_hold_err", error, exp_err);
    chk("single_load", n_load, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no end of test, expected finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [7:0] k;
    clear_plan();
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {res_inf, res_is_p, error}, 0);
    chk("rst_fault_cnt", fault_cnt, 0);
    chk("rst_op_code", bus.op_code, 0);
    chk("rst_pt_sel", bus.pt_sel, 0);
    chk("rst_strobes", {bus.key_load, bus.key_check, bus.keyfind_en, bus.keyscan_en, bus.pt_start}, 0);
    #1; RST_N = 1;

    // key == 0
    clear_plan();
    run_test(8'h00, "k00");
    chk("k00_res_inf", res_inf, 1);
    chk("k00_check", n_check, 1);
    chk("k00_no_pt_cmd", n_step + n_prest + n_final, 0);
    chk("k00_le8_cycles", (done_cyc - start_cyc) <= 8, 1);

    // key == 1
    run_test(8'h01, "k01");
    chk("k01_res_is_p", res_is_p, 1);
    chk("k01_no_find", n_find, 0);

    // 0xB4 clean
    run_test(8'hB4, "kb4");
    chk("kb4_steps", n_step, 7);
    chk("kb4_bits", obs_bits, 16'h0034);
    chk("kb4_final", n_final, 1);
    chk("kb4_fault_cnt", fault_cnt, 0);
    chk("kb4_snaps", n_snap, 8);
    chk("kb4_commits", n_commit, 8);

    // 0xB4, one fault on step 3
    clear_plan(); plan_faults[3] = 1;
    run_test(8'hB4, "kb4_f3");
    chk("kb4_f3_op11", n_oprest, 1);
    chk("kb4_f3_rest", n_prest, 1);
    chk("kb4_f3_bits", obs_bits, 16'h0074);
    chk("kb4_f3_fault_cnt", fault_cnt, 1);
    chk("kb4_f3_error", error, 0);

    // 0xB4, three faults on step 2 -> abort
    clear_plan(); plan_faults[2] = 3;
    run_test(8'hB4, "kb4_f2x3");
    chk("kb4_f2x3_error", error, 1);
    chk("kb4_f2x3_fault_cnt", fault_cnt, 3);
    chk("kb4_f2x3_no_final", n_final, 0);
    chk("kb4_f2x3_bits", obs_bits, 16'h0007);

    // reset while a step is in flight
    clear_plan(); scan_key = 8'hB4; build_expect(8'hB4); clear_obs();
    @(negedge CLK); #1; start = 1;
    @(negedge CLK); #1; start = 0;
    n = 0;
    while (!(bus.pt_sel == PT_STEP && !bus.pt_start) && n < 500) begin
      @(negedge CLK); #1; n++;
    end
    chk("rst_mid_reach_step_w", n < 500, 1);
    RST_N = 0;
    @(negedge CLK);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pt_sel", bus.pt_sel, 0);
    chk("rst_mid_op_code", bus.op_code, 0);
    chk("rst_mid_done", done, 0);
    #1; RST_N = 1;
    chk("rst_mid_no_done", done_seen, 0);
    run_test(8'hB4, "kb4_after_rst");
    chk("after_rst_bits", obs_bits, 16'h0034);

    // randomized keys and fault plans
    for (int r = 0; r < 24; r++) begin
      clear_plan();
      k = 8'($urandom_range(0, 255));
      if (r % 8 == 0) k = 8'h00;
      if (r % 8 == 1) k = 8'h01;
      for (int s = 1; s <= 8; s++)
        if ($urandom_range(0, 5) == 0) plan_faults[s] = $urandom_range(1, 3);
      plan_final = ($urandom_range(0, 7) == 0);
      run_test(k, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
